// File: rtl/imem_loadable.sv
// Loadable LEGv8 instruction memory: registered fetch port plus a valid/ready loader FSM.
// Optional IMEM_NOP_FILL_EN: each load rewrites the whole array, padding unloaded words with NOP_WORD.
module imem_loadable #(
  parameter int          N        = 32,
  parameter int          ADDR_W   = 6,
  parameter int          DEPTH    = 64,
  parameter logic [N-1:0] NOP_WORD = 32'h8b1f03ff
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  output logic [N-1:0]      q,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_count,
  input  logic              ld_valid,
  input  logic [N-1:0]      ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
);

  // state | meaning
  // IDLE  | fetch only; waits for ld_start
  // LOAD  | accepts ld_data on ld_valid until the clamped count is written
  // FILL  | (IMEM_NOP_FILL_EN) pads the rest of the array with NOP_WORD
  // DONE  | one-cycle ld_done pulse, fetch already allowed
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
`ifdef IMEM_NOP_FILL_EN
    FILL,
`endif
    DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [N-1:0] mem [DEPTH] = '{default: '0};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr, wptr_nxt, wptr_inc;
  logic [ADDR_W:0]   remaining, rem_nxt, clamp;
  logic              we;
  logic [N-1:0]      wdata, rd_word;
`ifdef IMEM_NOP_FILL_EN
  logic [ADDR_W:0]   fill_left, fill_nxt;
`endif

  assign clamp    = (ld_count > DEPTH_W) ? DEPTH_W : ld_count;
  assign wptr_inc = ({1'b0, wptr} == DEPTH_W - 1'b1) ? '0 : wptr + 1'b1;
  assign rd_word  = ({1'b0, addr} < DEPTH_W) ? mem[addr] : '0;

  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    rem_nxt   = remaining;
    we        = 1'b0;
    wdata     = ld_data;
    ld_ready  = 1'b0;
    ld_busy   = 1'b0;
    ld_done   = 1'b0;
`ifdef IMEM_NOP_FILL_EN
    fill_nxt  = fill_left;
`endif
    case (state)
      IDLE: begin
        if (ld_start) begin
          wptr_nxt = ld_base;
          rem_nxt  = clamp;
`ifdef IMEM_NOP_FILL_EN
          fill_nxt  = DEPTH_W - clamp;
          state_nxt = (clamp != '0) ? LOAD : FILL;
`else
          state_nxt = (clamp != '0) ? LOAD : DONE;
`endif
        end
      end
      LOAD: begin
        ld_busy  = 1'b1;
        ld_ready = 1'b1;
        if (ld_valid) begin
          we       = 1'b1;
          wptr_nxt = wptr_inc;
          rem_nxt  = remaining - 1'b1;
          if (remaining == 1) begin
`ifdef IMEM_NOP_FILL_EN
            // a full-depth load leaves nothing to pad
            state_nxt = (fill_left != '0) ? FILL : DONE;
`else
            state_nxt = DONE;
`endif
          end
        end
      end
`ifdef IMEM_NOP_FILL_EN
      FILL: begin
        ld_busy  = 1'b1;
        we       = 1'b1;
        wdata    = NOP_WORD;
        wptr_nxt = wptr_inc;
        fill_nxt = fill_left - 1'b1;
        if (fill_left == 1) state_nxt = DONE;
      end
`endif
      DONE: begin
        ld_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wptr      <= '0;
      remaining <= '0;
`ifdef IMEM_NOP_FILL_EN
      fill_left <= '0;
`endif
    end else begin
      state     <= state_nxt;
      wptr      <= wptr_nxt;
      remaining <= rem_nxt;
`ifdef IMEM_NOP_FILL_EN
      fill_left <= fill_nxt;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   q <= '0;
    else if (rd_en && !ld_busy)  q <= rd_word;
  end

  // Array is deliberately outside reset so an aborted load keeps what it wrote.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, wptr} < DEPTH_W)) mem[wptr] <= wdata;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised instruction memory for the pipelined LEGv8 core.
- Generalises the fixed 64x32 combinational ROM in three ways:
  - width and depth are parameters;
  - the fetch read is registered, with a fetch enable;
  - the contents can be loaded at runtime through a valid/ready loader port driven by a small FSM.
- Sits between the fetch-stage PC and the IF/ID register. The core stalls fetch while ld_busy is high.

Parameters:
- N, 32, instruction word width in bits.
- ADDR_W, 6, word-address width.
- DEPTH, 64, number of words; must be ≤ 2**ADDR_W.
- NOP_WORD, 32'h8b1f03ff, fill word (ADD XZR,XZR,XZR).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- addr  in  ADDR_W  fetch word address (PC[ADDR_W+1:2]).
- rd_en  in  1  fetch enable; 0 holds q.
- q  out  N  registered instruction word.
- ld_start  in  1  starts a load; sampled only in IDLE.
- ld_base  in  ADDR_W  first word address of the load.
- ld_count  in  ADDR_W+1  number of words to load.
- ld_valid  in  1  ld_data is valid.
- ld_data  in  N  word to write.
- ld_ready  out  1  loader accepts ld_data this cycle.
- ld_busy  out  1  load (or fill) in progress.
- ld_done  out  1  one-cycle pulse when the load completes.

Behaviour:
- Reset (async, immediate):
  - q=0, ld_ready=0, ld_busy=0, ld_done=0, state=IDLE.
  - Internal wptr=0, remaining=0.
  - Memory array is not cleared by reset; its power-up contents are all-zero via an initializer.
- Fetch:
  - When rd_en=1 and ld_busy=0, q <= mem[addr] at the next edge (latency 1).
  - Otherwise q holds its value.
  - addr ≥ DEPTH reads 0.
- FSM states: IDLE, LOAD, FILL, DONE.
- IDLE:
  - ld_ready=0, ld_busy=0.
  - On ld_start: wptr <= ld_base; remaining <= min(ld_count, DEPTH).
  - Go to LOAD if the clamped count > 0, else to DONE (FILL if the macro is defined).
- LOAD:
  - ld_busy=1, ld_ready=1.
  - On ld_valid: mem[wptr] <= ld_data; wptr <= (wptr+1) mod DEPTH (wraps from DEPTH-1 to 0); remaining--.
  - When the last word is accepted, go to FILL (macro defined) or DONE.
  - ld_valid=0 stalls the load indefinitely; there is no timeout.
- FILL (macro only):
  - ld_busy=1, ld_ready=0.
  - Writes NOP_WORD at wptr, one word per cycle, with wptr wrapping as in LOAD.
  - Total writes = DEPTH − clamped count, then go to DONE.
- DONE:
  - ld_done=1 and ld_busy=0 for exactly one cycle, then IDLE.
  - A fetch with rd_en=1 is already honoured in this cycle.
- ld_start outside IDLE is ignored.
- ld_valid outside LOAD is ignored (no write).
- In the ld_start cycle, ld_ready=0, so no data is accepted in that cycle.
- Reset mid-load aborts immediately to IDLE. Words already written stay in memory.

Optional Feature:
- Macro IMEM_NOP_FILL_EN.
- Defined: FILL state exists. Every load rewrites the whole memory: loaded words plus NOP_WORD in all other locations, continuing from the end of the load with wrap.
- Not defined: FILL is omitted. Words outside the loaded range keep their previous contents, and LOAD/zero-count go straight to DONE.

Test Plan:
1. Fetch timing:
   - Stimulus: after reset, rd_en=1, addr=0 → then addr=5 → then rd_en=0.
   - Response: q=0 before the first edge; q=mem[0] after edge 1 and mem[5] after edge 2; q holds while rd_en=0.
2. Basic load:
   - Stimulus: ld_start, base=2, count=3, data f8000001 / f8008002 / f8010003 with gaps in ld_valid.
   - Response:
     - ld_ready=1 only in LOAD;
     - ld_done pulses one cycle after the third accepted word (macro off);
     - reads of addr 2,3,4 return those words; addr 1 unchanged.
3. Wrap:
   - Stimulus: base=62, count=4, data A,B,C,D.
   - Response: mem[62]=A, mem[63]=B, mem[0]=C, mem[1]=D.
4. Edge cases:
   - Stimulus: count=0 → then count=100 with 64 words supplied.
   - Response:
     - count=0: ld_done one cycle after ld_start (macro off), no writes;
     - count=100: clamped to 64, done after the 64th word.
5. Busy gating:
   - Stimulus: ld_start mid-load; rd_en=1 while busy; reset asserted after 2 of 5 words.
   - Response:
     - the second ld_start is ignored;
     - q holds while busy;
     - reset gives ld_busy=0, q=0 immediately, and the 2 written words persist.
6. IMEM_NOP_FILL_EN:
   - Stimulus: base=10, count=2.
   - Response:
     - ld_busy is high for 2 accepted words + 62 fill cycles, then ld_done;
     - mem[10], mem[11] hold the loaded data; every other address reads 8b1f03ff.
